// File: rtl/gbuf_rd_arbiter_pkg.sv
// Shared widths for the global-buffer read path, scheduler states and a wrap-increment helper.
// Holds the word-geometry defaults that the rest of the gbuf read path is sized from.
package gbuf_rd_arbiter_pkg;

    localparam int WORD_ADDR_BITS = 8;
    localparam int WORD_SIZE      = 16;
    localparam int WORD_CNT       = 200;
    localparam int GBUF_LEN_BITS  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } gbuf_state_t;

    // n need not be a power of two, so the wrap is an explicit compare.
    function automatic int wrap_inc(input int v, input int n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/gbuf_rd_arbiter_if.sv
// Requester, SRAM read-port and response signals of the gbuf read scheduler.
// master = the arbiter itself, slave = the requesters/SRAM side.
interface gbuf_rd_arbiter_if
    import gbuf_rd_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = WORD_ADDR_BITS,
    parameter int DATA_W = WORD_SIZE,
    parameter int LEN_W  = GBUF_LEN_BITS
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ-1:0]        req_ready;
    logic                   sram_rd_valid;
    logic [ADDR_W-1:0]      sram_rd_addr;
    logic [DATA_W-1:0]      sram_do;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_last;
    logic [DATA_W-1:0]      rsp_data;
    logic                   busy;

    modport master (
        input  req_valid, req_addr, req_len, sram_do,
        output req_ready, sram_rd_valid, sram_rd_addr,
               rsp_valid, rsp_id, rsp_last, rsp_data, busy
    );

    modport slave (
        output req_valid, req_addr, req_len, sram_do,
        input  req_ready, sram_rd_valid, sram_rd_addr,
               rsp_valid, rsp_id, rsp_last, rsp_data, busy
    );

endinterface

// File: rtl/gbuf_rd_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping; one-hot grant plus index.
// Purely combinational; no backpressure of its own.
module gbuf_rd_arbiter_rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);
    logic found;
    int   cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/gbuf_rd_arbiter.sv
// Round-robin burst read scheduler for the gbuf SRAM: one read per cycle, responses tagged {id,last}.
// Accept->first issue 1 cycle, issue->response 1 cycle; no response backpressure, requesters wait in IDLE.
module gbuf_rd_arbiter
    import gbuf_rd_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = WORD_ADDR_BITS,
    parameter int DATA_W = WORD_SIZE,
    parameter int DEPTH  = WORD_CNT,
    parameter int LEN_W  = GBUF_LEN_BITS
) (
    input  logic              clk,
    input  logic              rst,
    gbuf_rd_arbiter_if.master bus
);
    localparam int ID_W = $clog2(NREQ);

    gbuf_state_t       state;
    logic [NREQ-1:0]   pick_gnt;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cur_id;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W-1:0]  beat;
    logic              last_beat;

    logic [NREQ-1:0]   req_ready;
    logic              sram_rd_valid;
    logic [ADDR_W-1:0] sram_rd_addr;
    logic [ID_W-1:0]   iss_id;
    logic              iss_last;
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic              rsp_last;
    logic              busy;
    logic [DATA_W-1:0] rd_word;

    gbuf_rd_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign last_beat = (beat == cur_len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cur_id        <= '0;
            cur_addr      <= '0;
            cur_len       <= '0;
            beat          <= '0;
            req_ready     <= '0;
            sram_rd_valid <= 1'b0;
            sram_rd_addr  <= '0;
            iss_id        <= '0;
            iss_last      <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_last      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            req_ready     <= '0;
            sram_rd_valid <= 1'b0;
            iss_last      <= 1'b0;
            // The SRAM registers DO, so the tag lags the issue by exactly one stage.
            rsp_valid     <= sram_rd_valid;
            rsp_id        <= iss_id;
            rsp_last      <= iss_last;
            case (state)
                IDLE: begin
                    busy <= sram_rd_valid;
                    if (|bus.req_valid) begin
                        req_ready <= pick_gnt;
                        cur_addr  <= bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        cur_len   <= bus.req_len[int'(pick_idx)*LEN_W +: LEN_W];
                        cur_id    <= pick_idx;
                        beat      <= '0;
                        rr_ptr    <= ID_W'(wrap_inc(int'(pick_idx), NREQ));
                        state     <= BURST;
                    end
                end
                BURST: begin
                    busy          <= 1'b1;
                    sram_rd_valid <= 1'b1;
                    sram_rd_addr  <= cur_addr;
                    iss_id        <= cur_id;
                    iss_last      <= last_beat;
                    cur_addr      <= ADDR_W'(wrap_inc(int'(cur_addr), DEPTH));
                    beat          <= beat + 1'b1;
                    if (last_beat) state <= IDLE;
                end
            endcase
        end
    end

    assign rd_word           = bus.sram_do;
    assign bus.rsp_data      = rd_word;
    assign bus.req_ready     = req_ready;
    assign bus.sram_rd_valid = sram_rd_valid;
    assign bus.sram_rd_addr  = sram_rd_addr;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.rsp_id        = rsp_id;
    assign bus.rsp_last      = rsp_last;
    assign bus.busy          = busy;

endmodule

// File: tb/tb_gbuf_rd_arbiter.sv
// Directed bench for gbuf_rd_arbiter with an SRAM model returning word(a) = a one cycle after issue.
module tb_gbuf_rd_arbiter;
    import gbuf_rd_arbiter_pkg::*;

    localparam int NREQ  = 3;
    localparam int AW    = WORD_ADDR_BITS;
    localparam int DW    = WORD_SIZE;
    localparam int DEPTH = WORD_CNT;
    localparam int LW    = GBUF_LEN_BITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gbuf_rd_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    gbuf_rd_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    typedef struct {
        int cyc;
        int val;
        int id;
        bit last;
    } ev_t;

    ev_t rsp_q[$];
    ev_t iss_q[$];
    ev_t gnt_q[$];
    int  cyc       = 0;
    int  multi_gnt = 0;
    int  checks    = 0;
    int  errors    = 0;
    int  left[NREQ];
    logic [DW-1:0] sram_q = '0;

    assign bus.sram_do = sram_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.sram_rd_valid) sram_q <= DW'(bus.sram_rd_addr);
    end

    always @(negedge clk) begin
        if (bus.rsp_valid)
            rsp_q.push_back('{cyc, int'(bus.rsp_data), int'(bus.rsp_id), bus.rsp_last});
        if (bus.sram_rd_valid)
            iss_q.push_back('{cyc, int'(bus.sram_rd_addr), 0, 1'b0});
        for (int i = 0; i < NREQ; i++)
            if (bus.req_ready[i]) gnt_q.push_back('{cyc, i, 0, 1'b0});
        if ($countones(bus.req_ready) > 1) multi_gnt++;
    end

    task automatic clear_q();
        rsp_q.delete();
        iss_q.delete();
        gnt_q.delete();
        multi_gnt = 0;
    endtask

    // Each requester drops its request once it has seen its allotted number of grants.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i] && left[i] > 0) begin
                    left[i]--;
                    if (left[i] == 0) bus.req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic request(input int r, input int addr, input int len, input int grants);
        bus.req_addr[r*AW +: AW] = AW'(addr);
        bus.req_len[r*LW +: LW]  = LW'(len);
        left[r]                  = grants;
        bus.req_valid[r]         = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int  n    = 0;
        bit  done = 1'b0;
        while (!done && n < budget) begin
            tick(1);
            n++;
            done = (bus.req_valid == '0) && (bus.req_ready == '0) && !bus.busy;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s idle_timeout: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic wait_grant(input string name, input int budget);
        int n = 0;
        while (gnt_q.size() == 0 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (gnt_q.size() == 0) begin
            errors++;
            $display("FAIL %s grant_timeout: no req_ready within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        tick(3);
        checks++; if (bus.req_ready !== '0)     begin errors++; $display("FAIL reset req_ready: got %b want 0", bus.req_ready); end
        checks++; if (bus.sram_rd_valid !== 0)  begin errors++; $display("FAIL reset sram_rd_valid: got %b want 0", bus.sram_rd_valid); end
        checks++; if (bus.sram_rd_addr !== '0)  begin errors++; $display("FAIL reset sram_rd_addr: got %0d want 0", bus.sram_rd_addr); end
        checks++; if (bus.rsp_valid !== 0)      begin errors++; $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== '0)        begin errors++; $display("FAIL reset rsp_id: got %0d want 0", bus.rsp_id); end
        checks++; if (bus.rsp_last !== 0)       begin errors++; $display("FAIL reset rsp_last: got %b want 0", bus.rsp_last); end
        checks++; if (bus.busy !== 0)           begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_round_robin();
        clear_q();
        request(0, 100, 0, 2);
        request(1, 110, 0, 2);
        request(2, 120, 0, 2);
        wait_idle("rr", 60);
        checks++; if (gnt_q.size() != 6) begin errors++; $display("FAIL rr grant_count: got %0d want 6", gnt_q.size()); end
        checks++; if (multi_gnt != 0)    begin errors++; $display("FAIL rr onehot: %0d multi-bit req_ready cycles, want 0", multi_gnt); end
        for (int k = 0; k < gnt_q.size(); k++) begin
            checks++;
            if (gnt_q[k].val != k % 3) begin errors++; $display("FAIL rr grant_order[%0d]: got %0d want %0d", k, gnt_q[k].val, k % 3); end
            if (k > 0) begin
                checks++;
                if (gnt_q[k].cyc - gnt_q[k-1].cyc != 2) begin
                    errors++; $display("FAIL rr grant_spacing[%0d]: got %0d want 2", k, gnt_q[k].cyc - gnt_q[k-1].cyc);
                end
            end
        end
        checks++; if (rsp_q.size() != 6) begin errors++; $display("FAIL rr rsp_count: got %0d want 6", rsp_q.size()); end
        for (int k = 0; k < rsp_q.size(); k++) begin
            checks++;
            if (rsp_q[k].id != k % 3 || rsp_q[k].val != 100 + 10 * (k % 3) || !rsp_q[k].last) begin
                errors++;
                $display("FAIL rr rsp[%0d]: got id %0d data %0d last %0d want id %0d data %0d last 1",
                         k, rsp_q[k].id, rsp_q[k].val, rsp_q[k].last, k % 3, 100 + 10 * (k % 3));
            end
        end
    endtask

    task automatic test_single();
        int g;
        clear_q();
        request(1, 5, 3, 1);
        wait_idle("single", 30);
        checks++;
        if (gnt_q.size() != 1 || gnt_q[0].val != 1) begin
            errors++; $display("FAIL single grant: got %0d grants, required exactly one to requester 1", gnt_q.size());
        end
        g = (gnt_q.size() > 0) ? gnt_q[0].cyc : 0;
        checks++; if (rsp_q.size() != 4) begin errors++; $display("FAIL single rsp_count: got %0d want 4", rsp_q.size()); end
        checks++; if (iss_q.size() != 4) begin errors++; $display("FAIL single iss_count: got %0d want 4", iss_q.size()); end
        for (int k = 0; k < rsp_q.size() && k < 4; k++) begin
            checks++;
            if (rsp_q[k].val != 5 + k || rsp_q[k].id != 1 || rsp_q[k].last != (k == 3) || rsp_q[k].cyc != g + 2 + k) begin
                errors++;
                $display("FAIL single rsp[%0d]: got data %0d id %0d last %0d cyc %0d want data %0d id 1 last %0d cyc %0d",
                         k, rsp_q[k].val, rsp_q[k].id, rsp_q[k].last, rsp_q[k].cyc, 5 + k, (k == 3), g + 2 + k);
            end
        end
        for (int k = 0; k < iss_q.size() && k < 4; k++) begin
            checks++;
            if (iss_q[k].val != 5 + k || iss_q[k].cyc != g + 1 + k) begin
                errors++;
                $display("FAIL single issue[%0d]: got addr %0d cyc %0d want addr %0d cyc %0d",
                         k, iss_q[k].val, iss_q[k].cyc, 5 + k, g + 1 + k);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_a[4];
        exp_a = '{DEPTH - 2, DEPTH - 1, 0, 1};
        clear_q();
        request(0, DEPTH - 2, 3, 1);
        wait_idle("wrap", 30);
        checks++; if (iss_q.size() != 4) begin errors++; $display("FAIL wrap iss_count: got %0d want 4", iss_q.size()); end
        checks++; if (rsp_q.size() != 4) begin errors++; $display("FAIL wrap rsp_count: got %0d want 4", rsp_q.size()); end
        for (int k = 0; k < iss_q.size() && k < 4; k++) begin
            checks++;
            if (iss_q[k].val != exp_a[k]) begin errors++; $display("FAIL wrap issue[%0d]: got addr %0d want %0d", k, iss_q[k].val, exp_a[k]); end
        end
        for (int k = 0; k < rsp_q.size() && k < 4; k++) begin
            checks++;
            if (rsp_q[k].val != exp_a[k] || rsp_q[k].id != 0) begin
                errors++; $display("FAIL wrap rsp[%0d]: got data %0d id %0d want data %0d id 0", k, rsp_q[k].val, rsp_q[k].id, exp_a[k]);
            end
        end
    endtask

    task automatic test_max_len();
        int nlast = 0;
        int exp_d;
        clear_q();
        request(2, 10, 255, 1);
        wait_idle("maxlen", 400);
        checks++; if (rsp_q.size() != 256) begin errors++; $display("FAIL maxlen rsp_count: got %0d want 256", rsp_q.size()); end
        for (int k = 0; k < rsp_q.size(); k++) begin
            exp_d = (10 + k < DEPTH) ? 10 + k : 10 + k - DEPTH;
            checks++;
            if (rsp_q[k].val != exp_d || rsp_q[k].id != 2) begin
                errors++; $display("FAIL maxlen rsp[%0d]: got data %0d id %0d want data %0d id 2", k, rsp_q[k].val, rsp_q[k].id, exp_d);
            end
            if (rsp_q[k].last) nlast++;
        end
        checks++;
        if (nlast != 1 || rsp_q.size() == 0 || !rsp_q[rsp_q.size()-1].last) begin
            errors++; $display("FAIL maxlen last: got %0d last beats, want exactly one on the final beat", nlast);
        end
    endtask

    task automatic test_mid_burst();
        int g0;
        clear_q();
        request(0, 20, 5, 1);
        wait_grant("mid", 10);
        g0 = (gnt_q.size() > 0) ? gnt_q[0].cyc : 0;
        tick(2);
        request(2, 40, 1, 1);
        wait_idle("mid", 40);
        checks++;
        if (gnt_q.size() != 2 || gnt_q[gnt_q.size()-1].val != 2 || gnt_q[gnt_q.size()-1].cyc != g0 + 7) begin
            errors++; $display("FAIL mid second_grant: got %0d grants (last cyc %0d) want requester 2 at cyc %0d",
                               gnt_q.size(), (gnt_q.size() > 0) ? gnt_q[gnt_q.size()-1].cyc : -1, g0 + 7);
        end
        checks++;
        if (iss_q.size() != 8 || iss_q[5].val != 25 || iss_q[5].cyc != g0 + 6 || iss_q[6].val != 40 || iss_q[6].cyc != g0 + 8) begin
            errors++; $display("FAIL mid issue: got %0d issues, want 8 with addr 25 at cyc %0d then addr 40 at cyc %0d",
                               iss_q.size(), g0 + 6, g0 + 8);
        end
        checks++;
        if (rsp_q.size() != 8 || rsp_q[5].id != 0 || !rsp_q[5].last || rsp_q[6].id != 2 || rsp_q[6].cyc != rsp_q[5].cyc + 2) begin
            errors++; $display("FAIL mid rsp: got %0d responses, want 8 with one-cycle gap between id 0 last and id 2", rsp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        clear_q();
        request(1, 50, 5, 1);
        wait_grant("rstmid", 10);
        tick(3);
        checks++;
        if (bus.sram_rd_valid !== 1 || bus.sram_rd_addr !== AW'(52) || bus.busy !== 1) begin
            errors++; $display("FAIL rstmid beat2: got valid %b addr %0d busy %b want 1 52 1", bus.sram_rd_valid, bus.sram_rd_addr, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.req_ready !== '0)     begin errors++; $display("FAIL rstmid req_ready: got %b want 0", bus.req_ready); end
        checks++; if (bus.sram_rd_valid !== 0)  begin errors++; $display("FAIL rstmid sram_rd_valid: got %b want 0", bus.sram_rd_valid); end
        checks++; if (bus.sram_rd_addr !== '0)  begin errors++; $display("FAIL rstmid sram_rd_addr: got %0d want 0", bus.sram_rd_addr); end
        checks++; if (bus.rsp_valid !== 0)      begin errors++; $display("FAIL rstmid rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== '0)        begin errors++; $display("FAIL rstmid rsp_id: got %0d want 0", bus.rsp_id); end
        checks++; if (bus.rsp_last !== 0)       begin errors++; $display("FAIL rstmid rsp_last: got %b want 0", bus.rsp_last); end
        checks++; if (bus.busy !== 0)           begin errors++; $display("FAIL rstmid busy: got %b want 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        clear_q();
        tick(6);
        checks++;
        if (rsp_q.size() != 0 || iss_q.size() != 0) begin
            errors++; $display("FAIL rstmid quiet: got %0d responses %0d issues after reset want 0 0", rsp_q.size(), iss_q.size());
        end
        request(1, 60, 0, 1);
        request(2, 70, 0, 1);
        wait_idle("rstmid", 30);
        checks++;
        if (gnt_q.size() != 2 || gnt_q[0].val != 1 || gnt_q[1].val != 2) begin
            errors++; $display("FAIL rstmid rr_restart: got %0d grants first %0d want 2 grants in order 1,2",
                               gnt_q.size(), (gnt_q.size() > 0) ? gnt_q[0].val : -1);
        end
        checks++;
        if (rsp_q.size() != 2 || rsp_q[0].val != 60 || rsp_q[1].val != 70) begin
            errors++; $display("FAIL rstmid rsp: got %0d responses want data 60 then 70", rsp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) left[i] = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_max_len();
        test_mid_burst();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
